// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU instruction/data channels and the downstream memory port.
// slave is the arbiter's view; master is the CPU and memory side.
interface mem_port_arbiter_if;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;
    logic        i_rdata_ready;

    logic        d_rd;
    logic        d_wr;
    logic        d_req_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic        d_rdata_ready;

    logic        m_req_valid;
    logic        m_req_ready;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_rdata_valid;
    logic        m_rdata_ready;

    modport slave (
        input  i_req_valid, i_addr, i_rdata_ready,
        input  d_rd, d_wr, d_addr, d_wdata, d_wstrb, d_rdata_ready,
        input  m_req_ready, m_rdata, m_rdata_valid,
        output i_req_ready, i_rdata, i_rdata_valid,
        output d_req_ready, d_rdata, d_rdata_valid,
        output m_req_valid, m_wen, m_addr, m_wdata, m_wstrb, m_rdata_ready
    );

    modport master (
        output i_req_valid, i_addr, i_rdata_ready,
        output d_rd, d_wr, d_addr, d_wdata, d_wstrb, d_rdata_ready,
        output m_req_ready, m_rdata, m_rdata_valid,
        input  i_req_ready, i_rdata, i_rdata_valid,
        input  d_req_ready, d_rdata, d_rdata_valid,
        input  m_req_valid, m_wen, m_addr, m_wdata, m_wstrb, m_rdata_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
// Accept in IDLE, replay from buffer in REQ, route the read response in RESP; losers wait with valid held.
module mem_port_arbiter #(
    parameter bit DATA_PRIO = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]     conflict_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, nxt;
    logic        sel_q, wen_q, last_grant;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        d_req, take, take_d, rdat_rdy;

    assign d_req = bus.d_rd | bus.d_wr;

    always_comb begin
        nxt               = state;
        take              = 1'b0;
        take_d            = 1'b0;
        rdat_rdy          = 1'b0;
        bus.i_req_ready   = 1'b0;
        bus.d_req_ready   = 1'b0;
        bus.m_req_valid   = 1'b0;
        bus.i_rdata_valid = 1'b0;
        bus.d_rdata_valid = 1'b0;
        case (state)
            IDLE: begin
                rdat_rdy = 1'b1;
                if (d_req || bus.i_req_valid) begin
                    take = 1'b1;
                    // last_grant=1 means D; round-robin hands a conflict to whoever did not win last
                    take_d = d_req && (!bus.i_req_valid || DATA_PRIO || !last_grant);
                    bus.d_req_ready = take_d;
                    bus.i_req_ready = !take_d;
                    nxt = REQ;
                end
            end
            REQ: begin
                bus.m_req_valid = 1'b1;
                if (bus.m_req_ready)
                    nxt = wen_q ? IDLE : RESP;
            end
            RESP: begin
                rdat_rdy          = sel_q ? bus.d_rdata_ready : bus.i_rdata_ready;
                bus.i_rdata_valid = !sel_q && bus.m_rdata_valid;
                bus.d_rdata_valid = sel_q && bus.m_rdata_valid;
                if (bus.m_rdata_valid && rdat_rdy)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.m_rdata_ready = rdat_rdy;
    assign bus.m_wen         = wen_q;
    assign bus.m_addr        = addr_q;
    assign bus.m_wdata       = wdata_q;
    assign bus.m_wstrb       = wstrb_q;
    assign bus.i_rdata       = bus.m_rdata;
    assign bus.d_rdata       = bus.m_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel_q        <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                sel_q      <= take_d;
                wen_q      <= take_d && bus.d_wr;
                addr_q     <= take_d ? bus.d_addr : bus.i_addr;
                wdata_q    <= take_d ? bus.d_wdata : 32'h0;
                wstrb_q    <= take_d ? bus.d_wstrb : 4'h0;
                last_grant <= take_d;
            end
            if (state == IDLE && d_req && bus.i_req_valid)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: fixed-priority instance for most scenarios, round-robin instance for alternation.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cnt_a, cnt_b;
    int          errors = 0;
    int          checks = 0;

    mem_port_arbiter_if a ();
    mem_port_arbiter_if b ();

    mem_port_arbiter #(.DATA_PRIO(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .bus(a), .conflict_cnt(cnt_a));
    mem_port_arbiter #(.DATA_PRIO(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .bus(b), .conflict_cnt(cnt_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        a.i_req_valid = 0; a.i_addr = 0; a.i_rdata_ready = 0;
        a.d_rd = 0; a.d_wr = 0; a.d_addr = 0; a.d_wdata = 0; a.d_wstrb = 0; a.d_rdata_ready = 0;
        a.m_req_ready = 0; a.m_rdata = 0; a.m_rdata_valid = 0;
        b.i_req_valid = 0; b.i_addr = 32'h300; b.i_rdata_ready = 1;
        b.d_rd = 0; b.d_wr = 0; b.d_addr = 32'h400; b.d_wdata = 0; b.d_wstrb = 0; b.d_rdata_ready = 1;
        b.m_req_ready = 1; b.m_rdata = 32'h1; b.m_rdata_valid = 1;

        // reset state
        tick(); tick();
        chk("rst_i_req_ready", a.i_req_ready, 0);
        chk("rst_d_req_ready", a.d_req_ready, 0);
        chk("rst_m_req_valid", a.m_req_valid, 0);
        chk("rst_m_rdata_ready", a.m_rdata_ready, 1);
        chk("rst_i_rdata_valid", a.i_rdata_valid, 0);
        chk("rst_d_rdata_valid", a.d_rdata_valid, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_m_addr", a.m_addr, 0);
        rst = 0;

        // I-only read
        tick();
        a.i_req_valid = 1; a.i_addr = 32'h100; a.i_rdata_ready = 1; a.m_req_ready = 1;
        #1;
        chk("i_grant", a.i_req_ready, 1);
        chk("i_grant_d_ready", a.d_req_ready, 0);
        tick();
        a.i_req_valid = 0;
        #1;
        chk("i_m_req_valid", a.m_req_valid, 1);
        chk("i_m_addr", a.m_addr, 32'h100);
        chk("i_m_wen", a.m_wen, 0);
        chk("i_no_accept_in_req", a.i_req_ready, 0);
        tick();
        a.m_rdata = 32'h13; a.m_rdata_valid = 1;
        #1;
        chk("i_rdata_valid", a.i_rdata_valid, 1);
        chk("i_rdata", a.i_rdata, 32'h13);
        chk("i_d_rdata_valid", a.d_rdata_valid, 0);
        chk("i_m_rdata_ready", a.m_rdata_ready, 1);
        tick();
        a.m_rdata_valid = 0;
        #1;
        chk("i_done_valid", a.i_rdata_valid, 0);
        chk("i_done_m_req", a.m_req_valid, 0);

        // conflict with data priority
        a.i_req_valid = 1; a.i_addr = 32'h104; a.d_rd = 1; a.d_addr = 32'h2000; a.d_rdata_ready = 1;
        #1;
        chk("cf_d_ready", a.d_req_ready, 1);
        chk("cf_i_ready", a.i_req_ready, 0);
        tick();
        a.d_rd = 0;
        #1;
        chk("cf_m_addr_d", a.m_addr, 32'h2000);
        chk("cf_cnt", cnt_a, 1);
        chk("cf_i_wait", a.i_req_ready, 0);
        tick();
        a.m_rdata = 32'hCAFE; a.m_rdata_valid = 1;
        #1;
        chk("cf_d_rdata_valid", a.d_rdata_valid, 1);
        chk("cf_i_rdata_valid", a.i_rdata_valid, 0);
        chk("cf_d_rdata", a.d_rdata, 32'hCAFE);
        tick();
        a.m_rdata_valid = 0;
        #1;
        chk("cf_i_second", a.i_req_ready, 1);
        tick();
        a.i_req_valid = 0;
        #1;
        chk("cf_m_addr_i", a.m_addr, 32'h104);
        chk("cf_cnt_hold", cnt_a, 1);
        tick();
        a.m_rdata = 32'h5; a.m_rdata_valid = 1;
        #1;
        chk("cf_i_resp", a.i_rdata_valid, 1);
        tick();
        a.m_rdata_valid = 0;

        // write with delayed m_req_ready
        a.m_req_ready = 0;
        a.d_wr = 1; a.d_addr = 32'h40; a.d_wdata = 32'hDEADBEEF; a.d_wstrb = 4'b0011;
        #1;
        chk("wr_d_ready", a.d_req_ready, 1);
        tick();
        a.d_wr = 0; a.d_addr = 32'h0; a.d_wdata = 32'h0; a.d_wstrb = 4'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wr_valid", a.m_req_valid, 1);
            chk("wr_wen", a.m_wen, 1);
            chk("wr_addr", a.m_addr, 32'h40);
            chk("wr_wdata", a.m_wdata, 32'hDEADBEEF);
            chk("wr_wstrb", a.m_wstrb, 4'b0011);
            if (k < 2) tick();
        end
        a.m_req_ready = 1;
        tick();
        #1;
        chk("wr_idle_m_req", a.m_req_valid, 0);
        chk("wr_no_resp", a.d_rdata_valid, 0);
        chk("wr_idle_drain", a.m_rdata_ready, 1);

        // response stall
        a.i_req_valid = 1; a.i_addr = 32'h200; a.i_rdata_ready = 0;
        tick();
        a.i_req_valid = 0;
        tick();
        a.m_rdata = 32'h77; a.m_rdata_valid = 1;
        #1;
        chk("st_m_rdy0", a.m_rdata_ready, 0);
        chk("st_valid0", a.i_rdata_valid, 1);
        tick();
        #1;
        chk("st_m_rdy1", a.m_rdata_ready, 0);
        chk("st_valid1", a.i_rdata_valid, 1);
        chk("st_no_accept", a.i_req_ready, 0);
        tick();
        a.i_rdata_ready = 1;
        #1;
        chk("st_release", a.m_rdata_ready, 1);
        chk("st_data", a.i_rdata, 32'h77);
        tick();
        a.m_rdata_valid = 0;
        #1;
        chk("st_done", a.i_rdata_valid, 0);

        // reset mid-RESP then stray response
        a.i_req_valid = 1; a.i_addr = 32'h300;
        tick();
        a.i_req_valid = 0;
        tick();
        #1;
        chk("rr_in_resp", a.m_rdata_ready, 1);
        rst = 1;
        #1;
        chk("rr_cnt_clr", cnt_a, 0);
        chk("rr_idle_rdy", a.m_rdata_ready, 1);
        tick();
        rst = 0;
        a.m_rdata = 32'h99; a.m_rdata_valid = 1;
        #1;
        chk("rr_stray_i", a.i_rdata_valid, 0);
        chk("rr_stray_d", a.d_rdata_valid, 0);
        chk("rr_stray_rdy", a.m_rdata_ready, 1);
        tick();
        a.m_rdata_valid = 0;
        #1;
        chk("rr_no_replay", a.m_req_valid, 0);
        chk("rr_cnt", cnt_a, 0);

        // round-robin: I-only first so last_grant becomes I
        b.i_req_valid = 1;
        #1;
        chk("rb_i_only", b.i_req_ready, 1);
        tick();
        b.i_req_valid = 0;
        tick(); tick();
        b.i_req_valid = 1; b.d_rd = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rb_d_grant", b.d_req_ready, (k % 2 == 0) ? 1 : 0);
            chk("rb_i_grant", b.i_req_ready, (k % 2 == 0) ? 0 : 1);
            tick();
            if (k == 3) begin
                b.i_req_valid = 0; b.d_rd = 0;
            end
            tick(); tick();
        end
        #1;
        chk("rb_cnt", cnt_b, 4);
        chk("rb_idle", b.m_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
